// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with run/halt/stall control and a circular
// return-address stack for call/return redirects. All outputs are registered.
module program_counter_ras #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
  parameter int                STALL_CYCLES = 1,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exec,
  input  logic                       is_halt_commanded,
  input  logic                       enable,
  input  logic                       is_data_hazard_stall,
  input  logic                       is_branch_hazard_stall,
  input  logic [ADDR_W-1:0]          branch_hazard_instr_add,
  input  logic                       is_cmpb_satisfied,
  input  logic [ADDR_W-1:0]          cmpb_instr_add,
  input  logic                       is_jump,
  input  logic [ADDR_W-1:0]          jump_instr_add,
  input  logic                       is_call,
  input  logic                       is_return,
  input  logic                       is_branch_predict,
  input  logic [ADDR_W-1:0]          branch_predict_add,
  output logic [ADDR_W-1:0]          instr_add,
  output logic                       instr_add_is_overflow,
  output logic                       is_halted,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_underflow
);

  localparam int          PW        = $clog2(RAS_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);
  localparam logic [3:0]  STALL_LIM = 4'(STALL_CYCLES);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          stall_q, stall_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]       ras_ptr;   // next free slot; top of stack is ras_ptr-1
  logic [CW-1:0]       ras_cnt;
  logic [ADDR_W-1:0]   ras_top;
  logic                push, pop;
  logic                run_eval, allow_seq;

  assign ras_top = ras_mem[ras_ptr - 1'b1];

  // Next-state, next-PC and stack-operation decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stall_d   = stall_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    run_eval  = 1'b0;
    allow_seq = 1'b0;
    if (is_halt_commanded) begin
      state_d = S_HALT;
      stall_d = '0;
    end else if (exec) begin
      state_d = (state_q == S_HALT) ? S_RUN : S_HALT;
      stall_d = '0;
    end else if (state_q != S_HALT && enable) begin
      unique case (state_q)
        S_INIT: begin
          // first fetch of the reset vector; redirects still take effect
          state_d  = S_RUN;
          run_eval = 1'b1;
        end
        S_RUN: begin
          if (!is_branch_hazard_stall && is_data_hazard_stall) begin
            state_d = S_STALL;
            stall_d = 4'd1;
          end else begin
            run_eval  = 1'b1;
            allow_seq = 1'b1;
          end
        end
        S_STALL: begin
          if (is_branch_hazard_stall || stall_q >= STALL_LIM) begin
            state_d   = S_RUN;
            stall_d   = '0;
            run_eval  = 1'b1;
            allow_seq = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
      if (run_eval) begin
        if (is_branch_hazard_stall) begin
          pc_d = branch_hazard_instr_add;
        end else if (is_cmpb_satisfied) begin
          pc_d = cmpb_instr_add;
        end else if (is_jump) begin
          pc_d = jump_instr_add;
          push = is_call;
        end else if (is_return) begin
          if (ras_cnt != '0) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            pc_d  = pc_q + 1'b1;
            unf_d = 1'b1;
          end
        end else if (is_branch_predict) begin
          pc_d = branch_predict_add;
        end else if (allow_seq) begin
          if (pc_q == {ADDR_W{1'b1}}) begin
            pc_d    = RESET_VEC;
            ovf_d   = 1'b1;
            state_d = S_INIT;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
    end
  end

  // State, PC, pulse and return-stack registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= RESET_VEC;
      stall_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push) begin
        // a full stack silently overwrites its oldest entry
        ras_mem[ras_ptr] <= pc_q + 1'b1;
        ras_ptr          <= ras_ptr + 1'b1;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        ras_ptr <= ras_ptr - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  assign instr_add             = pc_q;
  assign instr_add_is_overflow = ovf_q;
  assign is_halted             = (state_q == S_HALT);
  assign ras_count             = ras_cnt;
  assign ras_underflow         = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: directed scenarios plus randomized traffic
// checked against a behavioural model (PC integer, RAS as a queue).
module tb_program_counter_ras;
  localparam int ADDR_W = 12;
  localparam int STALL  = 3;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              exec, is_halt_commanded, enable;
  logic              is_data_hazard_stall, is_branch_hazard_stall;
  logic [ADDR_W-1:0] branch_hazard_instr_add, cmpb_instr_add, jump_instr_add, branch_predict_add;
  logic              is_cmpb_satisfied, is_jump, is_call, is_return, is_branch_predict;
  logic [ADDR_W-1:0] instr_add;
  logic              instr_add_is_overflow, is_halted, ras_underflow;
  logic [2:0]        ras_count;

  int total = 0;
  int bad   = 0;

  // behavioural model
  int m_pc;
  bit m_init, m_halted, m_stalled, m_ovf, m_unf;
  int m_bubbles;
  int ras_q[$];
  logic [ADDR_W-1:0] exp_q[$];

  program_counter_ras #(.ADDR_W(ADDR_W), .RESET_VEC(12'h000), .STALL_CYCLES(STALL), .RAS_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .exec(exec), .is_halt_commanded(is_halt_commanded),
    .enable(enable), .is_data_hazard_stall(is_data_hazard_stall),
    .is_branch_hazard_stall(is_branch_hazard_stall), .branch_hazard_instr_add(branch_hazard_instr_add),
    .is_cmpb_satisfied(is_cmpb_satisfied), .cmpb_instr_add(cmpb_instr_add),
    .is_jump(is_jump), .jump_instr_add(jump_instr_add), .is_call(is_call),
    .is_return(is_return), .is_branch_predict(is_branch_predict),
    .branch_predict_add(branch_predict_add), .instr_add(instr_add),
    .instr_add_is_overflow(instr_add_is_overflow), .is_halted(is_halted),
    .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    exec = 0; is_halt_commanded = 0; enable = 1;
    is_data_hazard_stall = 0; is_branch_hazard_stall = 0; branch_hazard_instr_add = '0;
    is_cmpb_satisfied = 0; cmpb_instr_add = '0; is_jump = 0; jump_instr_add = '0;
    is_call = 0; is_return = 0; is_branch_predict = 0; branch_predict_add = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_init = 1; m_halted = 0; m_stalled = 0; m_ovf = 0; m_unf = 0;
    m_bubbles = 0; ras_q.delete();
  endtask

  task automatic model_redirect(input bit seq);
    if (is_branch_hazard_stall) m_pc = branch_hazard_instr_add;
    else if (is_cmpb_satisfied) m_pc = cmpb_instr_add;
    else if (is_jump) begin
      if (is_call) begin
        ras_q.push_back((m_pc + 1) % 4096);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end
      m_pc = jump_instr_add;
    end else if (is_return) begin
      if (ras_q.size() > 0) m_pc = ras_q.pop_back();
      else begin m_pc = (m_pc + 1) % 4096; m_unf = 1; end
    end else if (is_branch_predict) m_pc = branch_predict_add;
    else if (seq) begin
      if (m_pc == 4095) begin m_pc = 0; m_ovf = 1; m_init = 1; end
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic model_edge();
    m_ovf = 0; m_unf = 0;
    if (is_halt_commanded) begin m_halted = 1; m_stalled = 0; m_init = 0; end
    else if (exec) begin
      if (m_halted) m_halted = 0;
      else begin m_halted = 1; m_stalled = 0; m_init = 0; end
    end
    else if (m_halted || !enable) begin end
    else if (m_init) begin m_init = 0; model_redirect(0); end
    else if (m_stalled) begin
      if (is_branch_hazard_stall) begin m_stalled = 0; m_pc = branch_hazard_instr_add; end
      else if (m_bubbles == 0) begin m_stalled = 0; model_redirect(1); end
      else m_bubbles--;
    end
    else if (!is_branch_hazard_stall && is_data_hazard_stall) begin
      m_stalled = 1; m_bubbles = STALL - 1;
    end
    else model_redirect(1);
  endtask

  // driver: one clock edge, model follows the same sampled inputs
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    model_reset();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] seq_exp [3];
    seq_exp[0] = 12'h000; seq_exp[1] = 12'h001; seq_exp[2] = 12'h002;
    clear_inputs();
    @(negedge clock);
    reset = 1;
    model_reset();
    #1;
    total++; if (instr_add !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", instr_add); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_ras got=%0d exp=0", ras_count); end
    total++; if (is_halted !== 1'b0 || instr_add_is_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b exp=000", is_halted, instr_add_is_overflow, ras_underflow);
    end
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (instr_add !== seq_exp[i]) begin bad++; $display("FAIL reset_seq%0d got=%h exp=%h", i, instr_add, seq_exp[i]); end
    end
  endtask

  task automatic test_overflow();
    is_jump = 1; jump_instr_add = 12'hFFD;
    step();
    clear_inputs();
    step(); step();
    total++; if (instr_add !== 12'hFFF) begin bad++; $display("FAIL ovf_top got=%h exp=fff", instr_add); end
    step();
    total++; if (instr_add !== 12'h000 || instr_add_is_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_wrap got=%h/%b exp=000/1", instr_add, instr_add_is_overflow);
    end
    step();
    total++; if (instr_add !== 12'h000 || instr_add_is_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_init_hold got=%h/%b exp=000/0", instr_add, instr_add_is_overflow);
    end
    step();
    total++; if (instr_add !== 12'h001) begin bad++; $display("FAIL ovf_resume got=%h exp=001", instr_add); end
  endtask

  task automatic test_call_return();
    is_jump = 1; jump_instr_add = 12'h010;
    step();
    is_call = 1; jump_instr_add = 12'h200;
    step();
    total++; if (instr_add !== 12'h200 || ras_count !== 3'd1) begin
      bad++; $display("FAIL call got=%h/%0d exp=200/1", instr_add, ras_count);
    end
    clear_inputs();
    step();
    is_return = 1;
    step();
    total++; if (instr_add !== 12'h011 || ras_count !== 3'd0) begin
      bad++; $display("FAIL return got=%h/%0d exp=011/0", instr_add, ras_count);
    end
    step();
    total++; if (instr_add !== 12'h012 || ras_underflow !== 1'b1) begin
      bad++; $display("FAIL underflow got=%h/%b exp=012/1", instr_add, ras_underflow);
    end
    clear_inputs();
    step();
    total++; if (instr_add !== 12'h013 || ras_underflow !== 1'b0) begin
      bad++; $display("FAIL underflow_pulse got=%h/%b exp=013/0", instr_add, ras_underflow);
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] hold_exp [4];
    hold_exp[0] = 12'h020; hold_exp[1] = 12'h020; hold_exp[2] = 12'h020; hold_exp[3] = 12'h021;
    is_jump = 1; jump_instr_add = 12'h020;
    step();
    clear_inputs();
    is_data_hazard_stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      is_data_hazard_stall = 0;
      total++; if (instr_add !== hold_exp[i]) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, instr_add, hold_exp[i]); end
    end
    is_jump = 1; jump_instr_add = 12'h020;
    step();
    clear_inputs();
    is_data_hazard_stall = 1;
    step();
    is_data_hazard_stall = 0;
    step();
    is_branch_hazard_stall = 1; branch_hazard_instr_add = 12'h080;
    step();
    total++; if (instr_add !== 12'h080) begin bad++; $display("FAIL stall_flush got=%h exp=080", instr_add); end
    clear_inputs();
    step();
    total++; if (instr_add !== 12'h081) begin bad++; $display("FAIL stall_flush_next got=%h exp=081", instr_add); end
    // async reset while stalled, with a stack entry present
    is_jump = 1; is_call = 1; jump_instr_add = 12'h030;
    step();
    clear_inputs();
    is_data_hazard_stall = 1;
    step();
    is_data_hazard_stall = 0;
    @(negedge clock);
    reset = 1;
    model_reset();
    #1;
    total++; if (instr_add !== 12'h000 || ras_count !== 3'd0) begin
      bad++; $display("FAIL reset_mid_stall got=%h/%0d exp=000/0", instr_add, ras_count);
    end
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_priority();
    is_cmpb_satisfied = 1; cmpb_instr_add = 12'h100;
    is_jump = 1; jump_instr_add = 12'h200;
    is_branch_predict = 1; branch_predict_add = 12'h300;
    step();
    total++; if (instr_add !== 12'h100) begin bad++; $display("FAIL prio_cmpb got=%h exp=100", instr_add); end
    is_branch_hazard_stall = 1; branch_hazard_instr_add = 12'h040;
    step();
    total++; if (instr_add !== 12'h040) begin bad++; $display("FAIL prio_flush got=%h exp=040", instr_add); end
    clear_inputs();
    is_branch_predict = 1; branch_predict_add = 12'h300;
    step();
    total++; if (instr_add !== 12'h300) begin bad++; $display("FAIL prio_predict got=%h exp=300", instr_add); end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [ADDR_W-1:0] frozen;
    exec = 1;
    step();
    exec = 0;
    frozen = 12'(m_pc);
    total++; if (is_halted !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b exp=1", is_halted); end
    is_jump = 1; jump_instr_add = 12'h777;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instr_add !== frozen || is_halted !== 1'b1) begin
        bad++; $display("FAIL halt_frozen%0d got=%h/%b exp=%h/1", i, instr_add, is_halted, frozen);
      end
    end
    clear_inputs();
    exec = 1;
    step();
    exec = 0;
    total++; if (is_halted !== 1'b0 || instr_add !== frozen) begin
      bad++; $display("FAIL halt_exit got=%h/%b exp=%h/0", instr_add, is_halted, frozen);
    end
    step();
    total++; if (instr_add !== frozen + 1'b1) begin bad++; $display("FAIL halt_advance got=%h exp=%h", instr_add, frozen + 1'b1); end
    exec = 1;
    step();
    is_halt_commanded = 1;
    step();
    total++; if (is_halted !== 1'b1) begin bad++; $display("FAIL halt_dominates got=%b exp=1", is_halted); end
    clear_inputs();
    exec = 1;
    step();
    exec = 0;
    total++; if (is_halted !== 1'b0) begin bad++; $display("FAIL halt_resume got=%b exp=0", is_halted); end
  endtask

  task automatic test_enable();
    logic [ADDR_W-1:0] held;
    clear_inputs();
    is_return = 1;  // stack is empty here
    step();
    held = 12'(m_pc);
    total++; if (ras_underflow !== 1'b1) begin bad++; $display("FAIL en_unf_set got=%b exp=1", ras_underflow); end
    enable = 0; is_return = 0; is_jump = 1; jump_instr_add = 12'h555;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (instr_add !== held || ras_underflow !== 1'b0) begin
        bad++; $display("FAIL en_hold%0d got=%h/%b exp=%h/0", i, instr_add, ras_underflow, held);
      end
    end
    clear_inputs();
  endtask

  task automatic test_ras_depth();
    do_reset();
    clear_inputs();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(12'((m_pc + 1) % 4096));
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      is_jump = 1; is_call = 1; jump_instr_add = 12'((k + 1) * 12'h100);
      step();
    end
    clear_inputs();
    total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ras_sat got=%0d exp=4", ras_count); end
    is_return = 1;
    for (int k = 0; k < DEPTH; k++) begin
      logic [ADDR_W-1:0] e;
      e = exp_q.pop_back();
      step();
      total++; if (instr_add !== e) begin bad++; $display("FAIL ras_pop%0d got=%h exp=%h", k, instr_add, e); end
    end
    step();
    total++; if (ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
      bad++; $display("FAIL ras_empty got=%b/%0d exp=1/0", ras_underflow, ras_count);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      exec                    = ($urandom_range(0, 24) == 0);
      is_halt_commanded       = ($urandom_range(0, 49) == 0);
      enable                  = ($urandom_range(0, 9) != 0);
      is_data_hazard_stall    = ($urandom_range(0, 11) == 0);
      is_branch_hazard_stall  = ($urandom_range(0, 19) == 0);
      is_cmpb_satisfied       = ($urandom_range(0, 19) == 0);
      is_jump                 = ($urandom_range(0, 9) == 0);
      is_call                 = ($urandom_range(0, 1) == 0);
      is_return               = ($urandom_range(0, 9) == 0);
      is_branch_predict       = ($urandom_range(0, 19) == 0);
      branch_hazard_instr_add = 12'($urandom);
      cmpb_instr_add          = 12'($urandom);
      jump_instr_add          = ($urandom_range(0, 3) == 0) ? 12'hFFC : 12'($urandom);
      branch_predict_add      = 12'($urandom);
      step();
      total++; if (instr_add !== 12'(m_pc)) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, instr_add, 12'(m_pc)); end
      total++; if (is_halted !== m_halted) begin bad++; $display("FAIL rnd_halt n=%0d got=%b exp=%b", n, is_halted, m_halted); end
      total++; if (instr_add_is_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, instr_add_is_overflow, m_ovf); end
      total++; if (ras_underflow !== m_unf) begin bad++; $display("FAIL rnd_unf n=%0d got=%b exp=%b", n, ras_underflow, m_unf); end
      total++; if (ras_count !== 3'(ras_q.size())) begin bad++; $display("FAIL rnd_ras n=%0d got=%0d exp=%0d", n, ras_count, ras_q.size()); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_overflow();
    test_call_return();
    test_stall();
    test_priority();
    test_halt();
    test_enable();
    test_ras_depth();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
- Parametrised next-generation fetch program counter for the simpleCPU pipeline.
- Generalises address width and reset vector.
- Replaces the single data-hazard bubble with a programmable stall length.
- Adds a circular return-address stack (RAS) for call/return redirects and an explicit run/halt/stall state machine.
- Sits at the IF stage and drives the instruction memory address.

Parameters:
- ADDR_W, 12: PC width in bits.
- RESET_VEC, 0: PC value after reset and after wrap.
- STALL_CYCLES, 1: bubbles inserted per data-hazard request (1..15).
- RAS_DEPTH, 4: return-stack entries (power of two, 2..16).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- exec, input, 1: toggles run/halt.
- is_halt_commanded, input, 1: forces halt.
- enable, input, 1: global advance enable.
- is_data_hazard_stall, input, 1: request STALL_CYCLES bubbles.
- is_branch_hazard_stall, input, 1: flush redirect.
- branch_hazard_instr_add, input, ADDR_W: flush target.
- is_cmpb_satisfied, input, 1: compare-branch taken.
- cmpb_instr_add, input, ADDR_W: compare-branch target.
- is_jump, input, 1: jump.
- jump_instr_add, input, ADDR_W: jump target.
- is_call, input, 1: qualifies is_jump as a call; push return address.
- is_return, input, 1: redirect to RAS top; pop.
- is_branch_predict, input, 1: predicted-taken redirect.
- branch_predict_add, input, ADDR_W: predicted target.
- instr_add, output, ADDR_W: current PC.
- instr_add_is_overflow, output, 1: one-cycle pulse on wrap.
- is_halted, output, 1: state == HALT.
- ras_count, output, $clog2(RAS_DEPTH)+1: valid RAS entries.
- ras_underflow, output, 1: one-cycle pulse on return with empty RAS.

Behaviour:
- Reset (async, any state, mid-stall included):
  - instr_add=RESET_VEC, state=INIT.
  - Overflow, underflow pulses 0; ras_count=0; stall counter 0; is_halted=0.
- States: INIT, RUN, STALL, HALT. All transitions occur on the rising clock edge.
- Halt control, evaluated first every cycle:
  - is_halt_commanded → HALT (dominates exec).
  - Else exec in HALT → RUN.
  - Else exec in any other state → HALT; a pending stall count is discarded.
  - In HALT, instr_add, RAS and counters hold.
- enable=0 in INIT/RUN/STALL: everything holds; pulses deassert.
- INIT, enabled: hold instr_add one cycle (first fetch of RESET_VEC), then → RUN. Redirect inputs in INIT are applied and also move to RUN.
- RUN, enabled, priority high→low:
  1. is_branch_hazard_stall: PC ← branch_hazard_instr_add. Overrides stall request. RAS untouched.
  2. is_data_hazard_stall: → STALL with counter=1, PC holds. If STALL_CYCLES=1, return to RUN next enabled cycle.
  3. is_cmpb_satisfied: PC ← cmpb_instr_add.
  4. is_jump: PC ← jump_instr_add. If is_call, push PC+1 (mod 2^ADDR_W).
  5. is_return:
     - RAS non-empty: PC ← top, pop.
     - Empty: PC ← PC+1, ras_underflow=1 for one cycle.
  6. is_branch_predict: PC ← branch_predict_add.
  7. Sequential:
     - PC < 2^ADDR_W−1: PC ← PC+1.
     - Else PC ← RESET_VEC, instr_add_is_overflow=1 one cycle, state → INIT.
- STALL, enabled:
  - PC holds and the counter increments.
  - When counter reaches STALL_CYCLES → RUN, with the same-cycle redirect evaluated by RUN priority (data stall ignored that cycle).
  - is_branch_hazard_stall in STALL: immediate redirect → RUN.
- RAS:
  - Circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - is_call without is_jump is ignored.
  - Call+return in the same cycle: jump wins, return ignored.
- Outputs are registered only, with no combinational input→output path.

Test Plan:
- Reset→3 enabled cycles, ADDR_W=12 → instr_add 0,0,1,2. Assert reset mid-STALL → instr_add=0 asynchronously, ras_count=0.
- Run PC to 0xFFF → next cycle instr_add=0x000, overflow pulse exactly one cycle, following cycle holds 0 (INIT).
- At PC=0x010: is_jump+is_call, target 0x200 → PC=0x200, ras_count=1. Two cycles later is_return → PC=0x011, ras_count=0. is_return again with RAS empty → PC+1, ras_underflow one cycle.
- STALL_CYCLES=3, data stall at PC=0x020 → PC holds 0x020 three cycles, then 0x021. Branch hazard to 0x080 during the second bubble → PC=0x080 next cycle.
- Same cycle: cmpb (0x100), jump (0x200), predict (0x300) → PC=0x100. Add branch_hazard (0x040) → PC=0x040.
- exec pulse → is_halted=1, PC frozen 5 cycles; exec again → advances. exec together with is_halt_commanded while halted → stays halted.
- RAS_DEPTH=4: push 5 calls (returns A..E) → ras_count=4; pops yield E,D,C,B, then underflow.
